// File: rtl/sequenciador_abc_if.sv
// rtl/sequenciador_abc_if.sv - control and stimulus-code bundle of the ABC sequencer
interface sequenciador_abc_if;
  logic start;
  logic pause;
  logic dir;
  logic A;
  logic B;
  logic C;
  logic valid;
  logic busy;
  logic done;

  modport master (
    output start, pause, dir,
    input  A, B, C, valid, busy, done
  );

  modport slave (
    input  start, pause, dir,
    output A, B, C, valid, busy, done
  );
endinterface

// File: rtl/sequenciador_abc.sv
// rtl/sequenciador_abc.sv - sweeps the 3-bit code {C,A,B} through all 8 values, DIV cycles each
module sequenciador_abc #(
  parameter int unsigned DIV = 4
) (
  input logic            clk,
  input logic            rst_n,
  sequenciador_abc_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0] PRESC_LAST = 4'(DIV - 1);

  state_t     state, state_nxt;
  logic [3:0] presc, presc_nxt;
  logic [2:0] step, step_nxt;
  logic [2:0] code, code_nxt;
  logic       dir_q, dir_nxt;
  logic       valid_q, valid_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;

  // A cycle counts toward the sweep only when sweeping and not held by pause.
  // Leaving PAUSE is itself a counting cycle, so each paused cycle costs exactly one.
  logic active;
  logic terminal;
  assign active   = ((state == RUN) || (state == PAUSE)) && !bus.pause;
  assign terminal = (presc == PRESC_LAST);

  // State and registered datapath/outputs; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      presc   <= '0;
      step    <= '0;
      code    <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      step    <= step_nxt;
      code    <= code_nxt;
      dir_q   <= dir_nxt;
      valid_q <= valid_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next-state: pause wins over a terminal count; DONE always falls back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.start) state_nxt = RUN;
      RUN, PAUSE: begin
        if (bus.pause)                        state_nxt = PAUSE;
        else if (terminal && (step == 3'd7))  state_nxt = DONE;
        else                                  state_nxt = RUN;
      end
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Next values of counters, code and output flags; outputs are registered from these.
  always_comb begin
    presc_nxt = presc;
    step_nxt  = step;
    code_nxt  = code;
    dir_nxt   = dir_q;
    valid_nxt = 1'b0;
    if ((state == IDLE) && bus.start) begin
      dir_nxt   = bus.dir;
      code_nxt  = {3{bus.dir}};
      presc_nxt = '0;
      step_nxt  = '0;
      valid_nxt = 1'b1;
    end else if (active) begin
      if (terminal) begin
        if (step != 3'd7) begin
          code_nxt  = dir_q ? (code - 3'd1) : (code + 3'd1);
          step_nxt  = step + 3'd1;
          presc_nxt = '0;
          valid_nxt = 1'b1;
        end
      end else begin
        presc_nxt = presc + 4'd1;
      end
    end
    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
    done_nxt = (state_nxt == DONE);
  end

  assign bus.C     = code[2];
  assign bus.A     = code[1];
  assign bus.B     = code[0];
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
